// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Contents: operand width, iteration counter width, op_sel encodings,
// engine state encodings and a two's-complement magnitude helper.
package mul_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  // Counter value on the final iteration cycle (DATA_W-1).
  localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0]   ONE_W     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE_2W    = {{(2*DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]   ZERO_W    = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   ONES_W    = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opSel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } mdState_e;

  // Absolute value for signed operands; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic isSigned);
    if (isSigned && v[DATA_W-1]) begin
      magnitude = (~v) + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// master: the core side (drives requests, observes busy/done/stall/HI/LO).
// slave : the multiply/divide unit.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic              op_start;
  logic [1:0]        op_sel;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic              mthi_we;
  logic              mtlo_we;
  logic              hilo_rd;
  logic              busy;
  logic              done;
  logic              stall;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output op_start, op_sel, SrcA, SrcB, mthi_we, mtlo_we, hilo_rd,
    input  busy, done, stall, HI, LO
  );

  modport slave (
    input  op_start, op_sel, SrcA, SrcB, mthi_we, mtlo_we, hilo_rd,
    output busy, done, stall, HI, LO
  );

endinterface

// File: rtl/mul_div_unit_md_core_iter.sv
// One combinational iteration of the multiply/divide engine.
// Ports: isDiv selects restore-divide step (1) or shift-add multiply step (0);
//        work is the 64-bit working register, operand the multiplicand/divisor;
//        workNext is the working register after this step.
// Multiply: work = {partial product upper, remaining multiplier bits}; add on LSB, shift right.
// Divide:   work = {partial remainder, remaining dividend bits / quotient bits}; shift left, restore.
module md_core_iter
  import mul_div_unit_pkg::*;
(
  input  logic                isDiv,
  input  logic [2*DATA_W-1:0] work,
  input  logic [DATA_W-1:0]   operand,
  output logic [2*DATA_W-1:0] workNext
);

  logic [DATA_W:0] addSum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Single shift-add or restoring step.
  always_comb begin
    addSum   = {1'b0, work[2*DATA_W-1:DATA_W]};
    // 33-bit partial remainder: current remainder with the next dividend bit shifted in.
    shifted  = work[2*DATA_W-1:DATA_W-1];
    diff     = shifted - {1'b0, operand};
    workNext = work;
    if (isDiv) begin
      if (shifted >= {1'b0, operand}) begin
        workNext = {diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
      end else begin
        workNext = {shifted[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
      end
    end else begin
      if (work[0]) begin
        addSum = {1'b0, work[2*DATA_W-1:DATA_W]} + {1'b0, operand};
      end else begin
        addSum = {1'b0, work[2*DATA_W-1:DATA_W]};
      end
      // Carry out of the add lands in the top bit as the product shifts right.
      workNext = {addSum, work[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Ports: clock, reset (synchronous, active-high); md (slave side of mul_div_unit_if):
//   op_start/op_sel/SrcA/SrcB launch an op, mthi_we/mtlo_we write HI/LO from SrcA,
//   hilo_rd flags an MFHI/MFLO; busy/done/stall report engine status; HI/LO registers.
// An op takes 32 iteration cycles plus one DONE cycle; HI/LO update on the edge leaving DONE.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input logic           clock,
  input logic           reset,
  mul_div_unit_if.slave md
);

  mdState_e            state;
  mdState_e            stateNext;
  logic [CNT_W-1:0]    iterCnt;
  logic [2*DATA_W-1:0] work;
  logic [2*DATA_W-1:0] workNext;
  logic [DATA_W-1:0]   operandB;
  logic [DATA_W-1:0]   rawA;
  logic [DATA_W-1:0]   hiReg;
  logic [DATA_W-1:0]   loReg;
  logic                signA;
  logic                signB;
  logic                opIsDiv;
  logic                divByZero;
  logic [DATA_W-1:0]   hiResult;
  logic [DATA_W-1:0]   loResult;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic                launchSigned;
  logic [DATA_W-1:0]   magA;
  logic [DATA_W-1:0]   magB;

  assign launchSigned = ~md.op_sel[0];
  assign magA         = magnitude(md.SrcA, launchSigned);
  assign magB         = magnitude(md.SrcB, launchSigned);

  md_core_iter uIter (
    .isDiv    (opIsDiv),
    .work     (work),
    .operand  (operandB),
    .workNext (workNext)
  );

  // Next-state decode for the engine FSM.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: begin
        if (md.op_start) begin
          stateNext = md.op_sel[1] ? S_DIV : S_MUL;
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (iterCnt == LAST_ITER) begin
          stateNext = S_DONE;
        end else begin
          stateNext = state;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Sign fixup of the finished product / quotient / remainder.
  always_comb begin
    product  = work;
    quot     = work[DATA_W-1:0];
    rem      = work[2*DATA_W-1:DATA_W];
    hiResult = hiReg;
    loResult = loReg;
    if (opIsDiv) begin
      if (divByZero) begin
        hiResult = rawA;
        loResult = ONES_W;
      end else begin
        // signA/signB are only set for signed ops, so unsigned results pass through.
        if (signA ^ signB) begin
          quot = (~work[DATA_W-1:0]) + ONE_W;
        end else begin
          quot = work[DATA_W-1:0];
        end
        if (signA) begin
          rem = (~work[2*DATA_W-1:DATA_W]) + ONE_W;
        end else begin
          rem = work[2*DATA_W-1:DATA_W];
        end
        hiResult = rem;
        loResult = quot;
      end
    end else begin
      if (signA ^ signB) begin
        product = (~work) + ONE_2W;
      end else begin
        product = work;
      end
      hiResult = product[2*DATA_W-1:DATA_W];
      loResult = product[DATA_W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Operand capture, iteration engine and HI/LO architectural registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      iterCnt   <= '0;
      work      <= '0;
      operandB  <= '0;
      rawA      <= '0;
      signA     <= 1'b0;
      signB     <= 1'b0;
      opIsDiv   <= 1'b0;
      divByZero <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md.op_start) begin
            // A launch wins over MTHI/MTLO issued in the same cycle.
            iterCnt   <= '0;
            rawA      <= md.SrcA;
            signA     <= launchSigned & md.SrcA[DATA_W-1];
            signB     <= launchSigned & md.SrcB[DATA_W-1];
            opIsDiv   <= md.op_sel[1];
            divByZero <= (md.SrcB == ZERO_W);
            if (md.op_sel[1]) begin
              work     <= {ZERO_W, magA};
              operandB <= magB;
            end else begin
              work     <= {ZERO_W, magB};
              operandB <= magA;
            end
          end else begin
            if (md.mthi_we) begin
              hiReg <= md.SrcA;
            end else begin
              hiReg <= hiReg;
            end
            if (md.mtlo_we) begin
              loReg <= md.SrcA;
            end else begin
              loReg <= loReg;
            end
          end
        end
        S_MUL, S_DIV: begin
          work    <= workNext;
          iterCnt <= iterCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_DONE: begin
          hiReg <= hiResult;
          loReg <= loResult;
        end
        default: begin
          hiReg <= hiReg;
        end
      endcase
    end
  end

  assign md.busy  = (state != S_IDLE);
  assign md.done  = (state == S_DONE);
  assign md.stall = md.busy & (md.hilo_rd | md.op_start | md.mthi_we | md.mtlo_we);
  assign md.HI    = hiReg;
  assign md.LO    = loReg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO from a plain-arithmetic model are queued
// at launch; a negedge monitor pops and compares when busy falls, and also checks the
// busy length (33) and a single done pulse per op.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  logic [63:0] sbq[$];
  logic [31:0] hiM = 32'h0;
  logic [31:0] loM = 32'h0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clock (clk),
    .reset (rst),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: HI/LO as the architecture defines them, from 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        ua, ub, uq, ur, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = 64'h0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic withMt);
    logic [63:0] e;
    e = refModel(op, a, b);
    sbq.push_back(e);
    hiM = e[63:32];
    loM = e[31:0];
    bus.op_start = 1'b1;
    bus.op_sel   = op;
    bus.SrcA     = a;
    bus.SrcB     = b;
    bus.mthi_we  = withMt;
    bus.mtlo_we  = withMt;
    @(negedge clk);
    check("stall_idle_launch", {31'h0, bus.stall}, 32'h0);
    tick();
    bus.op_start = 1'b0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
  endtask

  task automatic waitIdle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'h0, ok}, 32'h1);
    tick();
  endtask

  // Monitor: compare HI/LO, busy length and done count when busy falls.
  logic        prevBusy = 1'b0;
  int          busyCnt  = 0;
  int          doneCnt  = 0;
  logic [63:0] expEntry;
  always @(negedge clk) begin
    if (rst) begin
      prevBusy = 1'b0;
      busyCnt  = 0;
      doneCnt  = 0;
    end else begin
      if (bus.done) doneCnt++;
      if (bus.busy) busyCnt++;
      if (prevBusy && !bus.busy) begin
        if (sbq.size() == 0) begin
          check("unexpected_completion", 32'h1, 32'h0);
        end else begin
          expEntry = sbq.pop_front();
          check("HI", bus.HI, expEntry[63:32]);
          check("LO", bus.LO, expEntry[31:0]);
          check("busy_cycles", 32'(busyCnt), 32'd33);
          check("done_pulses", 32'(doneCnt), 32'd1);
        end
        busyCnt = 0;
        doneCnt = 0;
      end
      prevBusy = bus.busy;
    end
  end

  logic [31:0] hiOld, loOld;

  initial begin
    bus.op_start = 1'b0;
    bus.op_sel   = 2'b00;
    bus.SrcA     = 32'h0;
    bus.SrcB     = 32'h0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
    bus.hilo_rd  = 1'b0;
    rst          = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_stall", {31'h0, bus.stall}, 32'h0);
    check("rst_HI", bus.HI, 32'h0);
    check("rst_LO", bus.LO, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Directed cases.
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); waitIdle();
    check("multu_max_HI", bus.HI, 32'hFFFFFFFE);
    check("multu_max_LO", bus.LO, 32'h00000001);
    startOp(2'b00, 32'hFFFFFFFD, 32'h7, 1'b0);        waitIdle();
    check("mult_neg_HI", bus.HI, 32'hFFFFFFFF);
    check("mult_neg_LO", bus.LO, 32'hFFFFFFEB);
    startOp(2'b00, 32'h80000000, 32'h80000000, 1'b0); waitIdle();
    check("mult_min_HI", bus.HI, 32'h40000000);
    startOp(2'b10, 32'hFFFFFFF9, 32'h2, 1'b0);        waitIdle();
    check("div_neg_LO", bus.LO, 32'hFFFFFFFD);
    check("div_neg_HI", bus.HI, 32'hFFFFFFFF);
    startOp(2'b11, 32'h7, 32'h2, 1'b0);               waitIdle();
    startOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0); waitIdle();
    check("div_ovf_LO", bus.LO, 32'h80000000);
    startOp(2'b11, 32'h5, 32'h0, 1'b0);               waitIdle();
    check("divu_zero_HI", bus.HI, 32'h5);
    startOp(2'b10, 32'hFFFFFFF0, 32'h0, 1'b0);        waitIdle();
    check("div_zero_HI", bus.HI, 32'hFFFFFFF0);
    check("div_zero_LO", bus.LO, 32'hFFFFFFFF);

    // Requests held while busy: stall high, HI/LO untouched, requests dropped.
    hiOld = hiM;
    loOld = loM;
    startOp(2'b11, 32'd100, 32'd7, 1'b0);
    bus.op_start = 1'b1;
    bus.op_sel   = 2'b01;
    bus.mthi_we  = 1'b1;
    bus.SrcA     = 32'h1234;
    bus.hilo_rd  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_busy", {31'h0, bus.stall}, 32'h1);
      check("busy_HI_hold", bus.HI, hiOld);
      check("busy_LO_hold", bus.LO, loOld);
      tick();
    end
    bus.op_start = 1'b0;
    bus.mthi_we  = 1'b0;
    bus.hilo_rd  = 1'b0;
    waitIdle();

    // MTLO in IDLE with an MFHI/MFLO present: no stall, one-cycle write.
    bus.mtlo_we = 1'b1;
    bus.hilo_rd = 1'b1;
    bus.SrcA    = 32'hABCD;
    @(negedge clk);
    check("stall_idle_rd", {31'h0, bus.stall}, 32'h0);
    tick();
    bus.mtlo_we = 1'b0;
    bus.hilo_rd = 1'b0;
    loM = 32'hABCD;
    check("mtlo_LO", bus.LO, loM);
    check("mtlo_HI", bus.HI, hiM);
    bus.mthi_we = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.SrcA    = 32'h5A5A;
    tick();
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
    hiM = 32'h5A5A;
    loM = 32'h5A5A;
    check("mtboth_HI", bus.HI, hiM);
    check("mtboth_LO", bus.LO, loM);

    // Launch with MTHI/MTLO in the same cycle: writes dropped.
    hiOld = hiM;
    loOld = loM;
    startOp(2'b01, 32'h9, 32'h6, 1'b1);
    @(negedge clk);
    check("launch_mt_HI", bus.HI, hiOld);
    check("launch_mt_LO", bus.LO, loOld);
    waitIdle();

    // Reset at iteration 10 of a DIVU aborts the op.
    startOp(2'b11, 32'hDEADBEEF, 32'h1357, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    void'(sbq.pop_back());
    tick();
    rst = 1'b0;
    hiM = 32'h0;
    loM = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      check("abort_done", {31'h0, bus.done}, 32'h0);
      check("abort_HI", bus.HI, 32'h0);
      check("abort_LO", bus.LO, 32'h0);
      tick();
    end
    startOp(2'b01, 32'h3, 32'h4, 1'b0); waitIdle();
    check("multu_3x4_LO", bus.LO, 32'd12);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      startOp(2'($urandom_range(0, 3)), randOperand(), randOperand(), 1'b0);
      waitIdle();
    end

    tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
